// File: rtl/verin_pio_pkg.sv
// ============================================================================
// Module      : verin_pio_pkg
// Description : Register map and STATUS bit positions for the jack PIO pair.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package verin_pio_pkg;

    localparam logic [2:0] ADDR_DATA   = 3'd0;
    localparam logic [2:0] ADDR_OUT    = 3'd1;
    localparam logic [2:0] ADDR_MASK   = 3'd2;
    localparam logic [2:0] ADDR_LEN    = 3'd3;
    localparam logic [2:0] ADDR_SET    = 3'd4;
    localparam logic [2:0] ADDR_CLR    = 3'd5;
    localparam logic [2:0] ADDR_GO     = 3'd6;
    localparam logic [2:0] ADDR_STATUS = 3'd7;

    localparam int STATUS_BUSY   = 0;
    localparam int STATUS_DONE   = 1;
    localparam int STATUS_IRQ_EN = 2;

endpackage

`default_nettype wire

// File: rtl/verin_pulse_timer.sv
// ============================================================================
// Module      : verin_pulse_timer
// Description : Down-counter holding busy high for exactly len cycles.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module verin_pulse_timer #(
    parameter int LEN_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 start,
    input  logic [LEN_WIDTH-1:0] len,
    output logic                 busy,
    output logic                 done_pulse
);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    localparam logic [LEN_WIDTH-1:0] c_one = {{(LEN_WIDTH-1){1'b0}}, 1'b1};

    logic [0:0]           r_state;
    logic [LEN_WIDTH-1:0] r_count;
    logic                 r_busy;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
            r_count <= '0;
            r_busy  <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    // Starts while running never reach this branch, so a pulse cannot be extended.
                    if (start && (len != '0)) begin
                        r_count <= len;
                        r_busy  <= 1'b1;
                        r_state <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (r_count == c_one) begin
                        r_count <= '0;
                        r_busy  <= 1'b0;
                        r_state <= ST_IDLE;
                    end else begin
                        r_count <= r_count - c_one;
                    end
                end
                default: begin
                    r_count <= '0;
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy       = r_busy;
    assign done_pulse = (r_state == ST_RUN) && (r_count == c_one);

endmodule

`default_nettype wire

// File: rtl/verin_pio_out.sv
// ============================================================================
// Module      : verin_pio_out
// Description : Avalon-MM output PIO with set/clear and timed inversion pulse.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module verin_pio_out
    import verin_pio_pkg::*;
#(
    parameter int                    DATA_WIDTH  = 8,
    parameter int                    LEN_WIDTH   = 16,
    parameter logic [DATA_WIDTH-1:0] RESET_VALUE = {DATA_WIDTH{1'b0}}
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [2:0]            address,
    input  logic                  chipselect,
    input  logic                  write_n,
    input  logic [31:0]           writedata,
    output logic [31:0]           readdata,
    output logic [DATA_WIDTH-1:0] out_port,
    output logic                  irq
);

    logic [DATA_WIDTH-1:0] r_data;
    logic [DATA_WIDTH-1:0] r_mask;
    logic [LEN_WIDTH-1:0]  r_len;
    logic                  r_done;
    logic                  r_irq_en;
    logic [31:0]           r_readdata;

    logic                  w_wr;
    logic                  w_start;
    logic                  w_busy;
    logic                  w_done_pulse;
    logic [DATA_WIDTH-1:0] w_wdata;
    logic [31:0]           w_rd_mux;
    logic                  w_unused_wdata;

    assign w_wr           = chipselect & ~write_n;
    assign w_wdata        = writedata[DATA_WIDTH-1:0];
    assign w_start        = w_wr && (address == ADDR_GO) && writedata[0];
    assign w_unused_wdata = ^writedata;

    verin_pulse_timer #(
        .LEN_WIDTH (LEN_WIDTH)
    ) u_timer (
        .clk        (clk),
        .reset_n    (reset_n),
        .start      (w_start),
        .len        (r_len),
        .busy       (w_busy),
        .done_pulse (w_done_pulse)
    );

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_data   <= RESET_VALUE;
            r_mask   <= '0;
            r_len    <= '0;
            r_done   <= 1'b0;
            r_irq_en <= 1'b0;
        end else begin
            if (w_wr) begin
                case (address)
                    ADDR_DATA: r_data <= w_wdata;
                    ADDR_SET:  r_data <= r_data | w_wdata;
                    ADDR_CLR:  r_data <= r_data & ~w_wdata;
                    ADDR_MASK: if (!w_busy) r_mask <= w_wdata;
                    ADDR_LEN:  r_len <= writedata[LEN_WIDTH-1:0];
                    ADDR_STATUS: r_irq_en <= writedata[STATUS_IRQ_EN];
                    default: ;
                endcase
            end
            // Completion outranks a simultaneous write-1-to-clear.
            if (w_done_pulse) begin
                r_done <= 1'b1;
            end else if (w_wr && (address == ADDR_STATUS) && writedata[STATUS_DONE]) begin
                r_done <= 1'b0;
            end
        end
    end

    always_comb begin
        w_rd_mux = '0;
        case (address)
            ADDR_DATA:   w_rd_mux = 32'(r_data);
            ADDR_OUT:    w_rd_mux = 32'(out_port);
            ADDR_MASK:   w_rd_mux = 32'(r_mask);
            ADDR_LEN:    w_rd_mux = 32'(r_len);
            ADDR_STATUS: begin
                w_rd_mux[STATUS_BUSY]   = w_busy;
                w_rd_mux[STATUS_DONE]   = r_done;
                w_rd_mux[STATUS_IRQ_EN] = r_irq_en;
            end
            default:     w_rd_mux = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_readdata <= '0;
        end else begin
            r_readdata <= w_rd_mux;
        end
    end

    assign readdata = r_readdata;
    assign out_port = r_data ^ (r_mask & {DATA_WIDTH{w_busy}});
    assign irq      = r_done & r_irq_en;

endmodule

`default_nettype wire
